aead_stream_sequencer: RTL and testbench
========================================

AEAD_STREAM_SEQUENCER -- requirements
Module: aead_stream_sequencer

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have ports start (in, 1, begin one message, sampled in IDLE) and algo_sel (in, 1, 1=ChaCha20-Poly1305, 0=AES-GCM, latched on start).
REQ-004 SHALL have upstream beat ports in_valid (in, 1), in_ready (out, 1), in_data (in, 128), in_keep (in, 16, LSB-contiguous byte enables), in_is_pld (in, 1, 0=AAD 1=payload) and in_last (in, 1, last payload beat of message).
REQ-005 SHALL have core-facing ports aad_valid/aad_data[127:0]/aad_keep[15:0] (out), aad_ready (in), pld_valid/pld_data[127:0]/pld_keep[15:0] (out), pld_ready (in), len_valid/len_block[127:0] (out) and len_ready (in).
REQ-006 SHALL have tag inputs tag_pre_xor[127:0], tag_pre_xor_valid, tagmask[127:0], tagmask_valid, and outputs tag_out[127:0], tag_valid (1-cycle pulse), busy (1) and err (1, sticky until next start).

Function
REQ-007 SHALL implement FSM states IDLE, AAD, PLD, LEN, TAG; IDLE->AAD on start; start outside IDLE ignored.
REQ-008 In AAD, beats with in_is_pld=0 SHALL be forwarded to the aad_* channel; the first beat with in_is_pld=1 moves the FSM to PLD and is forwarded on pld_*.
REQ-009 SHALL hold each forwarded beat in a one-entry output register per channel; in_ready = target register empty or its downstream ready asserted this cycle; no beat lost or duplicated.
REQ-010 Output valid, data and keep SHALL stay stable while valid=1 and ready=0.
REQ-011 SHALL count aad_bytes and pld_bytes (64-bit each) by adding popcount(in_keep) on every accepted beat; counters wrap modulo 2^64.
REQ-012 A beat with in_is_pld=1, in_last=1, in_keep=0 SHALL be a terminator: consumed, not forwarded (supports empty payload and empty AAD).
REQ-013 An accepted beat with in_is_pld=0 while in PLD SHALL set err, be dropped, and not alter counters.
REQ-014 After the in_last payload beat has been accepted by the core, the FSM SHALL enter LEN and assert len_valid one cycle later.
REQ-015 len_block for ChaCha SHALL be {pld_bytes, aad_bytes} ([127:64]=payload bytes, [63:0]=AAD bytes); for GCM {aad_bytes*8, pld_bytes*8} ([127:64]=AAD bits).
REQ-016 On len_valid&&len_ready the FSM SHALL enter TAG and deassert len_valid.
REQ-017 In TAG, tag_pre_xor and tagmask SHALL be latched independently on their valids (any order, any gap).
REQ-018 One cycle after both are latched, tag_out SHALL equal (pre+mask) mod 2^128 for ChaCha or pre XOR mask for GCM, with tag_valid pulsed once; FSM returns to IDLE; tag_out held until next start.
REQ-019 busy SHALL be 1 in every state except IDLE; in_ready SHALL be 0 in IDLE, LEN and TAG.

Reset
REQ-020 On rst all outputs SHALL be 0, counters and latches cleared, FSM to IDLE, regardless of state or pending handshakes.
REQ-021 Reset deassertion SHALL require a start before any beat is accepted.

Structure
REQ-022 FSM state encoding and ALGO_CHACHA/ALGO_GCM constants SHALL live in shared package aead_pkg.
REQ-023 The per-channel output register SHALL be sub-module aead_beat_reg (valid/ready, 128+16 bits), instantiated twice.

Verification
REQ-024 ChaCha, AAD keep=0x0FFF, payload keep=0xFFFF last=1 -> len_block=0x0000000000000010_000000000000000C.
REQ-025 GCM, same stimulus -> len_block=0x0000000000000060_0000000000000080.
REQ-026 aad_ready held low 5 cycles with a beat pending -> aad_data/aad_keep unchanged, in_ready=0, exactly one transfer.
REQ-027 pre=all-ones, mask=1, mask arriving 3 cycles after pre -> ChaCha tag_out=0, GCM tag_out=0xFFFF..FFFE, one tag_valid pulse each.
REQ-028 Message with terminator only -> len_block lengths 0; AAD beat after payload -> err=1, beat not on aad_*.
REQ-029 rst asserted mid-PLD with pld_valid=1 -> all outputs 0 same cycle, busy=0, next start runs a clean message.

Source files
------------

// File: rtl/aead_pkg.sv
// Shared state encoding, algorithm selectors and helpers for the AEAD stream sequencer.
package aead_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AAD,
        ST_PLD,
        ST_LEN,
        ST_TAG
    } aead_state_t;

    localparam logic ALGO_CHACHA = 1'b1;
    localparam logic ALGO_GCM    = 1'b0;

    localparam int DATA_W = 128;
    localparam int KEEP_W = 16;

    // Number of valid bytes in a beat, from its byte-enable mask.
    function automatic logic [4:0] keep_bytes(input logic [KEEP_W-1:0] keep);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < KEEP_W; i++) begin
            n = n + {4'b0000, keep[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/aead_beat_reg.sv
// One-entry valid/ready holding register for a data+keep beat heading to the cipher core.
module aead_beat_reg
    import aead_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [KEEP_W-1:0] in_keep,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [KEEP_W-1:0] out_keep
);

    // A new beat may replace the held one in the same cycle it drains downstream.
    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_keep  <= '0;
        end else if (in_valid && in_ready) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
            out_keep  <= in_keep;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/aead_stream_sequencer.sv
// Splits one AEAD message into AAD / payload beats for the core, then emits the
// length block and combines the core's pre-tag with the tag mask.
module aead_stream_sequencer
    import aead_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         algo_sel,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic [15:0]  in_keep,
    input  logic         in_is_pld,
    input  logic         in_last,
    output logic         aad_valid,
    output logic [127:0] aad_data,
    output logic [15:0]  aad_keep,
    input  logic         aad_ready,
    output logic         pld_valid,
    output logic [127:0] pld_data,
    output logic [15:0]  pld_keep,
    input  logic         pld_ready,
    output logic         len_valid,
    output logic [127:0] len_block,
    input  logic         len_ready,
    input  logic [127:0] tag_pre_xor,
    input  logic         tag_pre_xor_valid,
    input  logic [127:0] tagmask,
    input  logic         tagmask_valid,
    output logic [127:0] tag_out,
    output logic         tag_valid,
    output logic         busy,
    output logic         err
);

    aead_state_t  state, state_next;
    logic         algo_q;
    logic         last_seen;
    logic [63:0]  aad_bytes, pld_bytes;
    logic [127:0] pre_q, mask_q;
    logic         pre_ok, mask_ok;
    logic         aad_push, pld_push, aad_in_ready, pld_in_ready;
    logic         is_term, accept, tag_fire;

    assign is_term  = in_is_pld && in_last && (in_keep == '0);
    assign accept   = in_valid && in_ready;
    assign tag_fire = (state == ST_TAG) && pre_ok && mask_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // LEN waits until both holding registers have drained into the core.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: if (start) state_next = ST_AAD;
            ST_AAD:  if (accept && in_is_pld) state_next = ST_PLD;
            ST_PLD:  if (last_seen && !aad_valid && !pld_valid) state_next = ST_LEN;
            ST_LEN:  if (len_ready) state_next = ST_TAG;
            ST_TAG:  if (tag_fire) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Terminators and misplaced AAD beats are always consumable; real beats need room.
    always_comb begin
        in_ready  = 1'b0;
        busy      = (state != ST_IDLE);
        len_valid = (state == ST_LEN);
        unique case (state)
            ST_AAD:  in_ready = in_is_pld ? (is_term || pld_in_ready) : aad_in_ready;
            ST_PLD:  in_ready = !last_seen && (!in_is_pld || is_term || pld_in_ready);
            default: in_ready = 1'b0;
        endcase
        aad_push = accept && (state == ST_AAD) && !in_is_pld;
        pld_push = accept && in_is_pld && !is_term;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            algo_q    <= ALGO_GCM;
            aad_bytes <= '0;
            pld_bytes <= '0;
            last_seen <= 1'b0;
            err       <= 1'b0;
        end else if (state == ST_IDLE && start) begin
            algo_q    <= algo_sel;
            aad_bytes <= '0;
            pld_bytes <= '0;
            last_seen <= 1'b0;
            err       <= 1'b0;
        end else if (accept) begin
            if (!in_is_pld) begin
                if (state == ST_PLD) begin
                    err <= 1'b1;
                end else begin
                    aad_bytes <= aad_bytes + 64'(keep_bytes(in_keep));
                end
            end else begin
                pld_bytes <= pld_bytes + 64'(keep_bytes(in_keep));
                if (in_last) begin
                    last_seen <= 1'b1;
                end
            end
        end
    end

    // Pre-tag and mask arrive independently; each is captured once per message.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q     <= '0;
            mask_q    <= '0;
            pre_ok    <= 1'b0;
            mask_ok   <= 1'b0;
            tag_out   <= '0;
            tag_valid <= 1'b0;
        end else begin
            tag_valid <= 1'b0;
            if (state == ST_IDLE && start) begin
                pre_ok  <= 1'b0;
                mask_ok <= 1'b0;
                tag_out <= '0;
            end else if (tag_fire) begin
                tag_out   <= (algo_q == ALGO_CHACHA) ? (pre_q + mask_q) : (pre_q ^ mask_q);
                tag_valid <= 1'b1;
                pre_ok    <= 1'b0;
                mask_ok   <= 1'b0;
            end else if (state == ST_TAG) begin
                if (tag_pre_xor_valid && !pre_ok) begin
                    pre_q  <= tag_pre_xor;
                    pre_ok <= 1'b1;
                end
                if (tagmask_valid && !mask_ok) begin
                    mask_q  <= tagmask;
                    mask_ok <= 1'b1;
                end
            end
        end
    end

    assign len_block = (algo_q == ALGO_CHACHA) ? {pld_bytes, aad_bytes}
                                               : {aad_bytes << 3, pld_bytes << 3};

    aead_beat_reg u_aad_reg (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (aad_push),
        .in_ready  (aad_in_ready),
        .in_data   (in_data),
        .in_keep   (in_keep),
        .out_valid (aad_valid),
        .out_ready (aad_ready),
        .out_data  (aad_data),
        .out_keep  (aad_keep)
    );

    aead_beat_reg u_pld_reg (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (pld_push),
        .in_ready  (pld_in_ready),
        .in_data   (in_data),
        .in_keep   (in_keep),
        .out_valid (pld_valid),
        .out_ready (pld_ready),
        .out_data  (pld_data),
        .out_keep  (pld_keep)
    );

endmodule

// File: tb/tb_aead_stream_sequencer.sv
// Self-checking bench for aead_stream_sequencer: directed corner cases plus random
// messages checked against a message-level reference model and beat scoreboard.
module tb_aead_stream_sequencer;

    logic         clk = 1'b0;
    logic         rst;
    logic         start, algo_sel;
    logic         in_valid, in_ready;
    logic [127:0] in_data;
    logic [15:0]  in_keep;
    logic         in_is_pld, in_last;
    logic         aad_valid, aad_ready;
    logic [127:0] aad_data;
    logic [15:0]  aad_keep;
    logic         pld_valid, pld_ready;
    logic [127:0] pld_data;
    logic [15:0]  pld_keep;
    logic         len_valid, len_ready;
    logic [127:0] len_block;
    logic [127:0] tag_pre_xor, tagmask, tag_out;
    logic         tag_pre_xor_valid, tagmask_valid, tag_valid;
    logic         busy, err;

    typedef struct packed {
        logic [127:0] d;
        logic [15:0]  k;
    } beat_t;

    int    vectors = 0;
    int    miscompares = 0;

    beat_t exp_aad[$], exp_pld[$];
    beat_t obs_aad[$], obs_pld[$];
    int    rd_aad = 0, rd_pld = 0;
    int    hold_viol_aad = 0, hold_viol_pld = 0;

    logic        m_algo, m_in_pld, m_err;
    logic [63:0] m_aad, m_pld;

    bit   rand_ready;
    logic aad_force, pld_force, aad_rnd, pld_rnd;

    always #5 clk = ~clk;

    assign aad_ready = rand_ready ? aad_rnd : aad_force;
    assign pld_ready = rand_ready ? pld_rnd : pld_force;

    aead_stream_sequencer dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .algo_sel          (algo_sel),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_data           (in_data),
        .in_keep           (in_keep),
        .in_is_pld         (in_is_pld),
        .in_last           (in_last),
        .aad_valid         (aad_valid),
        .aad_data          (aad_data),
        .aad_keep          (aad_keep),
        .aad_ready         (aad_ready),
        .pld_valid         (pld_valid),
        .pld_data          (pld_data),
        .pld_keep          (pld_keep),
        .pld_ready         (pld_ready),
        .len_valid         (len_valid),
        .len_block         (len_block),
        .len_ready         (len_ready),
        .tag_pre_xor       (tag_pre_xor),
        .tag_pre_xor_valid (tag_pre_xor_valid),
        .tagmask           (tagmask),
        .tagmask_valid     (tagmask_valid),
        .tag_out           (tag_out),
        .tag_valid         (tag_valid),
        .busy              (busy),
        .err               (err)
    );

    always @(posedge clk) begin
        #1;
        aad_rnd = ($urandom_range(0, 3) != 0);
        pld_rnd = ($urandom_range(0, 3) != 0);
    end

    // Core-side monitor: records every transfer and flags any stalled beat that changes.
    beat_t aad_prev, pld_prev;
    bit    aad_stall, pld_stall;
    always @(negedge clk or posedge rst) begin
        if (rst) begin
            aad_stall = 1'b0;
            pld_stall = 1'b0;
        end else begin
            if (aad_stall && !(aad_valid && aad_data === aad_prev.d && aad_keep === aad_prev.k))
                hold_viol_aad++;
            if (pld_stall && !(pld_valid && pld_data === pld_prev.d && pld_keep === pld_prev.k))
                hold_viol_pld++;
            if (aad_valid && aad_ready) obs_aad.push_back({aad_data, aad_keep});
            if (pld_valid && pld_ready) obs_pld.push_back({pld_data, pld_keep});
            aad_stall = aad_valid && !aad_ready;
            pld_stall = pld_valid && !pld_ready;
            aad_prev  = {aad_data, aad_keep};
            pld_prev  = {pld_data, pld_keep};
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] keepOf(input int nb);
        logic [31:0] t;
        t = (32'd1 << nb) - 32'd1;
        return t[15:0];
    endfunction

    function automatic logic [127:0] randData();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Reference model: what the core should see and how many bytes each section holds.
    task automatic modelAccept(input logic [127:0] d, input logic [15:0] k, input logic p, input logic l);
        if (!p && m_in_pld) begin
            m_err = 1'b1;
        end else if (!p) begin
            exp_aad.push_back({d, k});
            m_aad = m_aad + 64'($countones(k));
        end else begin
            m_in_pld = 1'b1;
            m_pld = m_pld + 64'($countones(k));
            if (!(l && k == 16'h0000)) exp_pld.push_back({d, k});
        end
    endtask

    task automatic applyStimulus(input logic [127:0] d, input logic [15:0] k, input logic p, input logic l);
        int n;
        n = 0;
        in_valid = 1'b1; in_data = d; in_keep = k; in_is_pld = p; in_last = l;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("in_ready_timeout", 128'(n < 200), 128'(1));
        if (in_ready) modelAccept(d, k, p, l);
        @(posedge clk); #1;
        in_valid = 1'b0; in_data = '0; in_keep = '0; in_is_pld = 1'b0; in_last = 1'b0;
    endtask

    task automatic startMsg(input logic algo);
        start = 1'b1; algo_sel = algo;
        @(posedge clk); #1;
        start = 1'b0;
        m_algo = algo; m_aad = '0; m_pld = '0; m_in_pld = 1'b0; m_err = 1'b0;
        checkOutput("busy_after_start", 128'(busy), 128'(1));
        checkOutput("err_after_start", 128'(err), 128'(0));
    endtask

    task automatic checkScoreboard();
        int n;
        checkOutput("aad_beat_count", 128'(obs_aad.size() - rd_aad), 128'(exp_aad.size()));
        n = obs_aad.size() - rd_aad;
        if (exp_aad.size() < n) n = exp_aad.size();
        for (int i = 0; i < n; i++) begin
            checkOutput("aad_beat_data", obs_aad[rd_aad + i].d, exp_aad[i].d);
            checkOutput("aad_beat_keep", 128'(obs_aad[rd_aad + i].k), 128'(exp_aad[i].k));
        end
        rd_aad = obs_aad.size();
        exp_aad.delete();
        checkOutput("pld_beat_count", 128'(obs_pld.size() - rd_pld), 128'(exp_pld.size()));
        n = obs_pld.size() - rd_pld;
        if (exp_pld.size() < n) n = exp_pld.size();
        for (int i = 0; i < n; i++) begin
            checkOutput("pld_beat_data", obs_pld[rd_pld + i].d, exp_pld[i].d);
            checkOutput("pld_beat_keep", 128'(obs_pld[rd_pld + i].k), 128'(exp_pld[i].k));
        end
        rd_pld = obs_pld.size();
        exp_pld.delete();
        checkOutput("aad_hold_violations", 128'(hold_viol_aad), 128'(0));
        checkOutput("pld_hold_violations", 128'(hold_viol_pld), 128'(0));
    endtask

    task automatic finishMsg(input logic [127:0] pre, input logic [127:0] mask, input bit pre_first,
                             input int gap, input bit lit_len_en, input logic [127:0] lit_len,
                             input bit lit_tag_en, input logic [127:0] lit_tag);
        int n, pulses;
        logic [127:0] exp_len, exp_tag;
        exp_len = m_algo ? {m_pld, m_aad} : {m_aad * 64'd8, m_pld * 64'd8};
        exp_tag = m_algo ? (pre + mask) : (pre ^ mask);
        n = 0;
        @(negedge clk);
        while (!len_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("len_valid", 128'(len_valid), 128'(1));
        checkOutput("len_block", len_block, exp_len);
        if (lit_len_en) checkOutput("len_block_literal", len_block, lit_len);
        checkOutput("in_ready_in_len", 128'(in_ready), 128'(0));
        checkOutput("err", 128'(err), 128'(m_err));
        checkScoreboard();
        @(posedge clk); #1;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        checkOutput("len_valid_held", 128'(len_valid), 128'(1));
        len_ready = 1'b1;
        @(posedge clk); #1;
        len_ready = 1'b0;
        checkOutput("len_valid_drop", 128'(len_valid), 128'(0));
        checkOutput("busy_in_tag", 128'(busy), 128'(1));
        if (gap == 0) begin
            tag_pre_xor = pre; tagmask = mask;
            tag_pre_xor_valid = 1'b1; tagmask_valid = 1'b1;
            @(posedge clk); #1;
        end else begin
            if (pre_first) begin tag_pre_xor = pre; tag_pre_xor_valid = 1'b1; end
            else begin tagmask = mask; tagmask_valid = 1'b1; end
            @(posedge clk); #1;
            tag_pre_xor_valid = 1'b0; tagmask_valid = 1'b0;
            tag_pre_xor = ~pre; tagmask = ~mask;
            repeat (gap - 1) begin @(posedge clk); #1; end
            checkOutput("tag_not_early", 128'(tag_valid), 128'(0));
            checkOutput("busy_waiting_tag", 128'(busy), 128'(1));
            if (pre_first) begin tagmask = mask; tagmask_valid = 1'b1; end
            else begin tag_pre_xor = pre; tag_pre_xor_valid = 1'b1; end
            @(posedge clk); #1;
        end
        tag_pre_xor_valid = 1'b0; tagmask_valid = 1'b0;
        tag_pre_xor = ~pre; tagmask = ~mask;
        pulses = 0;
        repeat (6) begin
            @(negedge clk);
            if (tag_valid) pulses++;
        end
        checkOutput("tag_valid_pulses", 128'(pulses), 128'(1));
        checkOutput("tag_out", tag_out, exp_tag);
        if (lit_tag_en) checkOutput("tag_out_literal", tag_out, lit_tag);
        checkOutput("busy_back_idle", 128'(busy), 128'(0));
        @(posedge clk); #1;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_in_ready"}, 128'(in_ready), 128'(0));
        checkOutput({tag, "_aad_valid"}, 128'(aad_valid), 128'(0));
        checkOutput({tag, "_aad_data"}, aad_data, 128'(0));
        checkOutput({tag, "_pld_valid"}, 128'(pld_valid), 128'(0));
        checkOutput({tag, "_pld_data"}, pld_data, 128'(0));
        checkOutput({tag, "_len_valid"}, 128'(len_valid), 128'(0));
        checkOutput({tag, "_len_block"}, len_block, 128'(0));
        checkOutput({tag, "_tag_valid"}, 128'(tag_valid), 128'(0));
        checkOutput({tag, "_tag_out"}, tag_out, 128'(0));
        checkOutput({tag, "_busy"}, 128'(busy), 128'(0));
        checkOutput({tag, "_err"}, 128'(err), 128'(0));
    endtask

    initial begin
        logic [127:0] d1;
        int na, np;
        bit inj;
        rst = 1'b1; start = 1'b0; algo_sel = 1'b0;
        in_valid = 1'b0; in_data = '0; in_keep = '0; in_is_pld = 1'b0; in_last = 1'b0;
        len_ready = 1'b0; tag_pre_xor = '0; tagmask = '0;
        tag_pre_xor_valid = 1'b0; tagmask_valid = 1'b0;
        rand_ready = 1'b1; aad_force = 1'b0; pld_force = 1'b0;
        m_algo = 1'b0; m_in_pld = 1'b0; m_err = 1'b0; m_aad = '0; m_pld = '0;
        $display("[TB] reset and idle checks");
        repeat (3) @(posedge clk);
        #1;
        checkAllZero("in_reset");
        rst = 1'b0;
        in_valid = 1'b1; in_keep = 16'hFFFF; in_data = randData();
        repeat (3) begin
            @(negedge clk);
            checkOutput("in_ready_idle", 128'(in_ready), 128'(0));
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_keep = '0; in_data = '0;
        checkAllZero("idle_after_reset");

        $display("[TB] length blocks and tag combine, ChaCha then GCM");
        startMsg(1'b1);
        applyStimulus(randData(), 16'h0FFF, 1'b0, 1'b0);
        applyStimulus(randData(), 16'hFFFF, 1'b1, 1'b1);
        finishMsg({128{1'b1}}, 128'd1, 1'b1, 3, 1'b1,
                  128'h0000000000000010_000000000000000C, 1'b1, 128'd0);
        startMsg(1'b0);
        applyStimulus(randData(), 16'h0FFF, 1'b0, 1'b0);
        applyStimulus(randData(), 16'hFFFF, 1'b1, 1'b1);
        finishMsg({128{1'b1}}, 128'd1, 1'b1, 3, 1'b1,
                  128'h0000000000000060_0000000000000080, 1'b1,
                  128'hFFFFFFFFFFFFFFFF_FFFFFFFFFFFFFFFE);

        $display("[TB] AAD back-pressure");
        rand_ready = 1'b0; aad_force = 1'b0; pld_force = 1'b1;
        startMsg(1'b1);
        d1 = randData();
        applyStimulus(d1, 16'hFFFF, 1'b0, 1'b0);
        in_valid = 1'b1; in_data = randData(); in_keep = 16'h00FF; in_is_pld = 1'b0; in_last = 1'b0;
        repeat (5) begin
            @(negedge clk);
            checkOutput("stall_in_ready", 128'(in_ready), 128'(0));
            checkOutput("stall_aad_valid", 128'(aad_valid), 128'(1));
            checkOutput("stall_aad_data", aad_data, d1);
            checkOutput("stall_aad_keep", 128'(aad_keep), 128'(16'hFFFF));
        end
        @(posedge clk); #1;
        aad_force = 1'b1;
        @(negedge clk);
        checkOutput("unstall_in_ready", 128'(in_ready), 128'(1));
        if (in_ready) modelAccept(in_data, in_keep, in_is_pld, in_last);
        @(posedge clk); #1;
        in_valid = 1'b0;
        rand_ready = 1'b1;
        applyStimulus(randData(), 16'h7FFF, 1'b1, 1'b1);
        finishMsg(randData(), randData(), 1'b0, 2, 1'b0, '0, 1'b0, '0);

        $display("[TB] terminator-only message and misplaced AAD");
        startMsg(1'b1);
        applyStimulus('0, 16'h0000, 1'b1, 1'b1);
        finishMsg(randData(), randData(), 1'b1, 0, 1'b1, 128'd0, 1'b0, '0);
        startMsg(1'b0);
        applyStimulus(randData(), 16'h00FF, 1'b0, 1'b0);
        applyStimulus(randData(), 16'hFFFF, 1'b1, 1'b0);
        applyStimulus(randData(), 16'hFFFF, 1'b0, 1'b0);
        checkOutput("err_after_misplaced_aad", 128'(err), 128'(1));
        applyStimulus(randData(), 16'h0007, 1'b1, 1'b1);
        finishMsg(randData(), randData(), 1'b1, 1, 1'b0, '0, 1'b0, '0);

        $display("[TB] reset during payload");
        rand_ready = 1'b0; aad_force = 1'b1; pld_force = 1'b0;
        startMsg(1'b0);
        applyStimulus(randData(), 16'hFFFF, 1'b0, 1'b0);
        applyStimulus(randData(), 16'hFFFF, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("pld_pending", 128'(pld_valid), 128'(1));
        #1 rst = 1'b1;
        #1;
        checkAllZero("mid_pld_reset");
        exp_pld.delete();
        checkScoreboard();
        @(posedge clk); #1;
        rst = 1'b0; rand_ready = 1'b1;
        startMsg(1'b1);
        applyStimulus(randData(), 16'h003F, 1'b0, 1'b0);
        applyStimulus(randData(), 16'h01FF, 1'b1, 1'b1);
        finishMsg(randData(), randData(), 1'b0, 1, 1'b1,
                  128'h0000000000000009_0000000000000006, 1'b0, '0);

        $display("[TB] random messages");
        for (int m = 0; m < 10; m++) begin
            startMsg(1'($urandom_range(0, 1)));
            na = $urandom_range(0, 3);
            np = $urandom_range(0, 3);
            inj = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < na; i++)
                applyStimulus(randData(), keepOf($urandom_range(0, 16)), 1'b0, 1'b0);
            for (int i = 0; i < np; i++) begin
                applyStimulus(randData(), keepOf($urandom_range(1, 16)), 1'b1, 1'(i == np - 1));
                if (inj && i == 0 && np > 1)
                    applyStimulus(randData(), keepOf($urandom_range(0, 16)), 1'b0, 1'b0);
            end
            if (np == 0) applyStimulus('0, 16'h0000, 1'b1, 1'b1);
            finishMsg(randData(), randData(), 1'($urandom_range(0, 1)), $urandom_range(0, 4),
                      1'b0, '0, 1'b0, '0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
